if_prefetch_stage: RTL and testbench
====================================

// Module: if_prefetch_stage
// PURPOSE
//  Parametrised instruction-fetch stage with a decoupled prefetch queue. It replaces the fixed single-cycle fetch.
//  Fetches run ahead of decode through a req/gnt/rvalid memory handshake with variable latency.
//  Fetched {pc+4, instruction} pairs are buffered in a DEPTH-entry FIFO; an IF/ID output register drains it.
//  Sits between the branch-resolution logic and the ID stage; honours freeze, flush and branch redirect.
// PARAMETERS
//  ADDR_WIDTH   32  fetch address / pc width
//  INSTR_WIDTH  32  instruction word width
//  DEPTH        4   prefetch FIFO entries; power of 2, >= 2
//  PC_STEP      4   address increment per fetch
//  RESET_PC     0   first fetch address after reset
// PORTS
//  clk              in   1            rising-edge clock
//  rst              in   1            asynchronous, active-low reset
//  freeze           in   1            hazard stall: hold output register, no pop
//  flush            in   1            clear output register to bubble
//  branch_taken     in   1            redirect fetch to branch_addr
//  branch_addr      in   ADDR_WIDTH   redirect target
//  imem_req         out  1            fetch request
//  imem_addr        out  ADDR_WIDTH   fetch address (= fetch_pc)
//  imem_gnt         in   1            request accepted this cycle
//  imem_rvalid      in   1            response valid (>= 1 cycle after gnt)
//  imem_rdata       in   INSTR_WIDTH  response instruction
//  pc_out           out  ADDR_WIDTH   IF/ID pc (fetch address + PC_STEP)
//  instruction_out  out  INSTR_WIDTH  IF/ID instruction
//  valid_out        out  1            IF/ID entry holds a real instruction
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, FIFO empty (count=0), state=IDLE.
//    Outputs during reset: imem_req=0, pc_out=0, instruction_out=0, valid_out=0.
//    Reset mid-transaction abandons the transaction; an rvalid arriving in IDLE is ignored.
//  - FSM, at most one outstanding request:
//    IDLE = nothing outstanding; WAIT = one granted request outstanding; DROP = outstanding response must be discarded.
//  - imem_req = !branch_taken && state!=DROP && (state==IDLE || imem_rvalid) && (count + (state==WAIT)) < DEPTH.
//    imem_addr = fetch_pc, held stable while req && !gnt.
//  - req && gnt: fetch_pc += PC_STEP (mod 2^ADDR_WIDTH); state -> WAIT.
//  - WAIT && rvalid: push {addr+PC_STEP, rdata}.
//    State -> IDLE, unless a new grant lands in the same cycle, in which case it stays WAIT.
//    Back-to-back fetch therefore sustains 1 instruction/cycle when rvalid follows gnt by 1 cycle.
//  - branch_taken (priority over everything):
//    - FIFO cleared; fetch_pc <= branch_addr; imem_req=0 this cycle.
//    - Output register cleared: valid_out=0, pc_out=0, instruction_out=0.
//    - State: WAIT && !rvalid -> DROP. WAIT && rvalid -> response discarded, IDLE. IDLE -> IDLE.
//    - Branch while in DROP stays DROP, with the new target.
//  - DROP && rvalid: response discarded; -> IDLE; no request that cycle.
//  - Output register (next state), priority order:
//    - branch_taken or flush -> bubble (zeros, valid 0); flush overrides freeze.
//    - else freeze -> hold; no pop.
//    - else count>0 -> load FIFO head, valid 1, pop.
//    - else -> bubble.
//  - Push and pop in the same cycle: count unchanged. Request gating guarantees no push while full.
//    Pop on empty is impossible by construction.
//  - FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//  - Latency: rvalid edge -> valid_out at the next edge when the FIFO was empty and freeze=0.
// TESTING
//  1 Reset low, then release, gnt=1, rvalid 1 cycle after gnt, freeze=0.
//    -> imem_addr 0,4,8,...; valid_out rises 2 cycles after first gnt; pc_out 4,8,12 consecutive.
//  2 freeze=1 for 10 cycles, DEPTH=4.
//    -> exactly 4 responses accepted, then imem_req=0; outputs held.
//    On release: 4 buffered instructions drain in order, no loss, no duplicate.
//  3 branch_taken with branch_addr=0x100 while WAIT and no rvalid.
//    -> DROP; late rdata never appears on outputs; next imem_addr=0x100; FIFO empty; valid_out=0.
//  4 branch_taken in the same cycle as rvalid -> response discarded; next request to target.
//    Branch again while in DROP -> last target wins.
//  5 flush=1 with freeze=1 -> bubble loaded (flush wins), FIFO contents kept.
//    Random gnt/rvalid delays 0-5 cycles -> in-order stream, valid_out never 1 with stale pc.
//  6 fetch_pc=2^ADDR_WIDTH-4 -> next address 0 (wrap).
//    rst asserted mid-WAIT -> all outputs 0 immediately (async); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: runs fetches ahead of decode over a req/gnt/rvalid
// memory port, buffers {pc+step, instr} pairs in a small FIFO, drains into IF/ID.
module if_prefetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter int                    PC_STEP     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_addr,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   valid_out
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]          count_reg;
  logic [ADDR_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0]  instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_out_reg;
  logic [INSTR_WIDTH-1:0]  instr_out_reg;
  logic                    valid_out_reg;

  logic                    in_wait;
  logic [PTR_W+1:0]        occupancy;
  logic                    fire;
  logic                    push;
  logic                    pop;

  // Occupancy counts the outstanding response so a full FIFO can never be pushed.
  assign in_wait   = (state_reg == WAIT);
  assign occupancy = (PTR_W+2)'(count_reg) + (PTR_W+2)'(in_wait);
  assign imem_req  = rst && !branch_taken && (state_reg != DROP) &&
                     ((state_reg == IDLE) || imem_rvalid) &&
                     (occupancy < (PTR_W+2)'(DEPTH));
  assign imem_addr = fetch_pc_reg;
  assign fire      = imem_req && imem_gnt;
  assign push      = in_wait && imem_rvalid && !branch_taken;
  assign pop       = !branch_taken && !flush && !freeze && (count_reg != '0);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    if (branch_taken) begin
      fetch_pc_next = branch_addr;
    end else if (fire) begin
      fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(PC_STEP);
    end
    case (state_reg)
      IDLE: if (fire) state_next = WAIT;
      WAIT: begin
        if (branch_taken)     state_next = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_next = fire ? WAIT : IDLE;
      end
      // The stale response still has to arrive; a further branch only retargets fetch_pc.
      DROP: if (imem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  // While WAIT, fetch_pc already equals the outstanding address + PC_STEP.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (branch_taken) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
      else if (pop && !push) count_reg <= count_reg - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out_reg    <= '0;
      instr_out_reg <= '0;
      valid_out_reg <= 1'b0;
    end else if (branch_taken || flush) begin
      pc_out_reg    <= '0;
      instr_out_reg <= '0;
      valid_out_reg <= 1'b0;
    end else if (!freeze) begin
      if (pop) begin
        pc_out_reg    <= pc_mem[rd_ptr_reg];
        instr_out_reg <= instr_mem[rd_ptr_reg];
        valid_out_reg <= 1'b1;
      end else begin
        pc_out_reg    <= '0;
        instr_out_reg <= '0;
        valid_out_reg <= 1'b0;
      end
    end
  end

  assign pc_out          = pc_out_reg;
  assign instruction_out = instr_out_reg;
  assign valid_out       = valid_out_reg;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a single-outstanding memory responder
// whose latency and response stall are set by the test steps.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  int          checks = 0;
  int          errors = 0;

  bit          pending;
  int          cnt;
  logic [31:0] paddr;
  int          lat;
  bit          stall;

  if_prefetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .flush           (flush),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the handshake before the edge, then update the responder.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    logic        rv;
    #1;
    fire = imem_req && imem_gnt;
    a    = imem_addr;
    rv   = imem_rvalid;
    @(posedge clk);
    #1;
    if (rv) pending = 1'b0;
    if (fire) begin
      pending = 1'b1;
      cnt     = lat;
      paddr   = a;
    end
    if (pending && !stall && cnt > 0) cnt--;
    imem_rvalid = pending && (cnt == 0);
    imem_rdata  = imem_rvalid ? instr_of(paddr) : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    pending      = 1'b0;
    cnt          = 0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    freeze       = 1'b0;
    flush        = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_instr", instruction_out, 0);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc;
    int          n;

    imem_gnt = 1'b1;
    lat      = 1;
    stall    = 1'b0;

    // 1: back-to-back fetch, 1 instruction per cycle
    do_reset();
    chk("t1_req0", imem_req, 1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_valid_e1", valid_out, 0);
    tick();
    chk("t1_addr8", imem_addr, 32'h8);
    chk("t1_valid_e2", valid_out, 0);
    tick();
    chk("t1_valid_e3", valid_out, 1);
    chk("t1_pc4", pc_out, 32'h4);
    chk("t1_ins0", instruction_out, 32'hC0DE0000);
    tick();
    chk("t1_pc8", pc_out, 32'h8);
    chk("t1_ins4", instruction_out, 32'hC0DE0004);
    tick();
    chk("t1_pc12", pc_out, 32'hC);
    chk("t1_ins8", instruction_out, 32'hC0DE0008);

    // 2: freeze fills the FIFO and stops requesting, then drains in order
    freeze = 1'b1;
    tick();
    tick();
    chk("t2_req_full", imem_req, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_req_hold", imem_req, 0);
      chk("t2_pc_hold", pc_out, 32'hC);
    end
    chk("t2_addr", imem_addr, 32'h1C);
    chk("t2_valid_hold", valid_out, 1);
    freeze = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_drain_pc", pc_out, 32'h10 + 32'(i) * 4);
      chk("t2_drain_ins", instruction_out, 32'hC0DE000C + 32'(i) * 4);
      chk("t2_drain_valid", valid_out, 1);
    end

    // 3: branch while WAIT without rvalid -> DROP, late data discarded
    stall = 1'b1;
    do_reset();
    tick();
    chk("t3_req_wait", imem_req, 0);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    #1;
    chk("t3_req_branch", imem_req, 0);
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    #1;
    chk("t3_req_drop", imem_req, 0);
    chk("t3_valid_drop", valid_out, 0);
    tick();
    chk("t3_req_drop_rv", imem_req, 0);
    tick();
    chk("t3_req_target", imem_req, 1);
    chk("t3_addr_target", imem_addr, 32'h100);
    chk("t3_valid_e4", valid_out, 0);
    tick();
    chk("t3_valid_e5", valid_out, 0);
    tick();
    chk("t3_valid_e6", valid_out, 0);
    tick();
    chk("t3_valid_e7", valid_out, 1);
    chk("t3_pc", pc_out, 32'h104);
    chk("t3_ins", instruction_out, 32'hC0DE0100);

    // 4: branch with rvalid, then repeated branch in DROP
    do_reset();
    tick();
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    #1;
    chk("t4_req_branch_rv", imem_req, 0);
    tick();
    branch_taken = 1'b0;
    stall        = 1'b1;
    #1;
    chk("t4_req_target", imem_req, 1);
    chk("t4_addr_target", imem_addr, 32'h200);
    tick();
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    tick();
    branch_addr  = 32'h400;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    #1;
    chk("t4_req_drop", imem_req, 0);
    chk("t4_valid_drop", valid_out, 0);
    tick();
    chk("t4_req_drop_rv", imem_req, 0);
    tick();
    chk("t4_req_last", imem_req, 1);
    chk("t4_addr_last", imem_addr, 32'h400);
    tick();
    tick();
    chk("t4_valid_e9", valid_out, 0);
    tick();
    chk("t4_valid_e10", valid_out, 1);
    chk("t4_pc", pc_out, 32'h404);
    chk("t4_ins", instruction_out, 32'hC0DE0400);

    // 5: flush beats freeze, FIFO contents survive
    do_reset();
    tick();
    tick();
    tick();
    chk("t5_pc_pre", pc_out, 32'h4);
    freeze = 1'b1;
    flush  = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_valid", valid_out, 0);
    chk("t5_flush_pc", pc_out, 0);
    chk("t5_flush_ins", instruction_out, 0);
    freeze = 1'b0;
    tick();
    chk("t5_kept_pc8", pc_out, 32'h8);
    chk("t5_kept_ins4", instruction_out, 32'hC0DE0004);
    tick();
    chk("t5_kept_pc12", pc_out, 32'hC);
    chk("t5_kept_ins8", instruction_out, 32'hC0DE0008);

    // 5b: random grant delay and response latency, stream must stay in order
    do_reset();
    exp_pc = 32'h4;
    n      = 0;
    for (int cyc = 0; cyc < 400 && n < 12; cyc++) begin
      imem_gnt = 1'($urandom_range(0, 1));
      lat      = int'($urandom_range(1, 5));
      tick();
      if (valid_out) begin
        chk("t5_rnd_pc", pc_out, exp_pc);
        chk("t5_rnd_ins", instruction_out, instr_of(exp_pc - 32'h4));
        exp_pc += 32'h4;
        n++;
      end
    end
    chk("t5_rnd_count", n, 12);

    // 6: address wrap, then async reset mid-WAIT
    imem_gnt = 1'b0;
    lat      = 1;
    do_reset();
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    imem_gnt     = 1'b1;
    #1;
    chk("t6_req_top", imem_req, 1);
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_addr_wrap", imem_addr, 32'h0);
    tick();
    stall = 1'b1;
    tick();
    chk("t6_valid", valid_out, 1);
    chk("t6_pc_wrap", pc_out, 32'h0);
    chk("t6_ins_top", instruction_out, 32'hC0DEFFFC);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_valid", valid_out, 0);
    chk("t6_async_pc", pc_out, 0);
    chk("t6_async_ins", instruction_out, 0);
    chk("t6_async_req", imem_req, 0);
    pending     = 1'b0;
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
